// File: rtl/sc_randuart_pkg.sv
// Shared types and constants for the random-value UART transmitter.
// SC_RANDUART_PARITY_EN adds an even-parity bit and the StParity state.
package sc_randuart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;
  localparam int unsigned START_BITS           = 1;
  localparam int unsigned STOP_BITS            = 1;

`ifdef SC_RANDUART_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  localparam int unsigned PARITY_BITS = 0;
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  localparam int unsigned FRAME_OVERHEAD_BITS = START_BITS + PARITY_BITS + STOP_BITS;

  // Clock cycles occupied by one frame of the given word width and bit time.
  function automatic int unsigned frame_cycles(input int unsigned data_width,
                                               input int unsigned clks_per_bit);
    return (data_width + FRAME_OVERHEAD_BITS) * clks_per_bit;
  endfunction

endpackage

// File: rtl/sc_randuart_baudgen.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 while running and pulses tick on the last count.
module sc_randuart_baudgen
  import sc_randuart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == CntW'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (!run || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sc_randuart.sv
// UART transmitter that frames a word captured on a falling edge of the load strobe.
// Define SC_RANDUART_PARITY_EN to append an even-parity bit before the stop bit.
module sc_randuart
  import sc_randuart_pkg::*;
#(
  parameter int unsigned DATAWIDTH    = 8,
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 SC_RANDUART_CLOCK_50,
  input  logic                 SC_RANDUART_RESET_InLow,
  input  logic                 SC_RANDUART_load_InLow,
  input  logic [DATAWIDTH-1:0] SC_RANDUART_data_InBUS,
  output logic                 SC_RANDUART_tx_Out,
  output logic                 SC_RANDUART_busy_Out,
  output logic                 SC_RANDUART_drop_Out
);

  localparam int unsigned IdxW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;

  state_e                 state_q;
  logic [DATAWIDTH-1:0]   shift_q;
  logic [DATAWIDTH-1:0]   shift_nxt;
  logic [IdxW-1:0]        idx_q;
  logic                   load_hist_q;
  logic                   tx_q;
  logic                   busy_q;
  logic                   drop_q;
  logic                   load_evt;
  logic                   bit_tick;
  logic                   run;
`ifdef SC_RANDUART_PARITY_EN
  logic                   parity_q;
`endif

  // History resets high, so a strobe already low at reset release still counts.
  assign load_evt  = load_hist_q && !SC_RANDUART_load_InLow;
  assign run       = (state_q != StIdle);
  assign shift_nxt = shift_q >> 1;

  sc_randuart_baudgen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baudgen (
    .clk  (SC_RANDUART_CLOCK_50),
    .rst_n(SC_RANDUART_RESET_InLow),
    .run  (run),
    .tick (bit_tick)
  );

  always_ff @(posedge SC_RANDUART_CLOCK_50) begin
    if (!SC_RANDUART_RESET_InLow) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      idx_q       <= '0;
      load_hist_q <= 1'b1;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      drop_q      <= 1'b0;
`ifdef SC_RANDUART_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      load_hist_q <= SC_RANDUART_load_InLow;
      drop_q      <= load_evt && (state_q != StIdle);
      case (state_q)
        StIdle: begin
          if (load_evt) begin
            shift_q <= SC_RANDUART_data_InBUS;
            idx_q   <= '0;
            state_q <= StStart;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
`ifdef SC_RANDUART_PARITY_EN
            parity_q <= ^SC_RANDUART_data_InBUS;
`endif
          end
        end
        StStart: begin
          if (bit_tick) begin
            state_q <= StData;
            tx_q    <= shift_q[0];
          end
        end
        StData: begin
          if (bit_tick) begin
            if (idx_q == IdxW'(DATAWIDTH - 1)) begin
              idx_q <= '0;
`ifdef SC_RANDUART_PARITY_EN
              state_q <= StParity;
              tx_q    <= parity_q;
`else
              state_q <= StStop;
              tx_q    <= 1'b1;
`endif
            end else begin
              idx_q   <= idx_q + IdxW'(1);
              shift_q <= shift_nxt;
              tx_q    <= shift_nxt[0];
            end
          end
        end
`ifdef SC_RANDUART_PARITY_EN
        StParity: begin
          if (bit_tick) begin
            state_q <= StStop;
            tx_q    <= 1'b1;
          end
        end
`endif
        StStop: begin
          if (bit_tick) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign SC_RANDUART_tx_Out   = tx_q;
  assign SC_RANDUART_busy_Out = busy_q;
  assign SC_RANDUART_drop_Out = drop_q;

endmodule

// File: tb/tb_sc_randuart.sv
// Self-checking bench for sc_randuart against a frame-queue reference model.
// Honours SC_RANDUART_PARITY_EN to expect the parity bit.
module tb_sc_randuart;

  localparam int unsigned DW  = 8;
  localparam int unsigned CPB = 4;
`ifdef SC_RANDUART_PARITY_EN
  localparam int unsigned NBITS = DW + 3;
`else
  localparam int unsigned NBITS = DW + 2;
`endif
  localparam int unsigned FRAME_CYC = NBITS * CPB;

  logic          clk;
  logic          rst_n;
  logic          load_n;
  logic [DW-1:0] data;
  logic          tx;
  logic          busy;
  logic          drop;

  sc_randuart #(
    .DATAWIDTH   (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .SC_RANDUART_CLOCK_50   (clk),
    .SC_RANDUART_RESET_InLow(rst_n),
    .SC_RANDUART_load_InLow (load_n),
    .SC_RANDUART_data_InBUS (data),
    .SC_RANDUART_tx_Out     (tx),
    .SC_RANDUART_busy_Out   (busy),
    .SC_RANDUART_drop_Out   (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: expected line levels, one entry per clock cycle.
  bit exp_q[$];
  bit prev_load = 1'b1;
  bit exp_tx    = 1'b1;
  bit exp_busy  = 1'b0;
  bit exp_drop  = 1'b0;

  int frames      = 0;
  int busy_cycles = 0;
  int drops       = 0;
  bit busy_prev   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [DW-1:0] d);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < int'(DW); i++) bits.push_back(d[i]);
`ifdef SC_RANDUART_PARITY_EN
    bits.push_back(^d);
`endif
    bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int k = 0; k < int'(CPB); k++) exp_q.push_back(bits[i]);
    end
  endtask

  task automatic model_step();
    bit ev;
    if (!rst_n) begin
      exp_q.delete();
      exp_tx    = 1'b1;
      exp_busy  = 1'b0;
      exp_drop  = 1'b0;
      prev_load = 1'b1;
    end else begin
      ev        = prev_load && !load_n;
      exp_drop  = ev && exp_busy;
      if (ev && !exp_busy) push_frame(data);
      prev_load = load_n;
      if (exp_q.size() > 0) begin
        exp_tx   = exp_q.pop_front();
        exp_busy = 1'b1;
      end else begin
        exp_tx   = 1'b1;
        exp_busy = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("tx", 32'(tx), 32'(exp_tx));
    check_eq("busy", 32'(busy), 32'(exp_busy));
    check_eq("drop", 32'(drop), 32'(exp_drop));
    if (busy === 1'b1 && !busy_prev) frames++;
    if (busy === 1'b1) busy_cycles++;
    if (drop === 1'b1) drops++;
    busy_prev = (busy === 1'b1);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic load_pulse(input logic [DW-1:0] d);
    load_n = 1'b0;
    data   = d;
    cycle();
    load_n = 1'b1;
    data   = DW'($urandom);
  endtask

  task automatic clear_counts();
    frames      = 0;
    busy_cycles = 0;
    drops       = 0;
  endtask

  initial begin
    rst_n  = 1'b0;
    load_n = 1'b1;
    data   = '0;
    @(negedge clk);
    run_cycles(3);
    rst_n = 1'b1;

    // Idle after reset.
    clear_counts();
    run_cycles(20);
    check_eq("idle_frames", 32'(frames), 32'd0);

    // Single frame, busy length.
    clear_counts();
    load_pulse(8'hA5);
    run_cycles(FRAME_CYC + 8);
    check_eq("a5_busy_cycles", 32'(busy_cycles), 32'(FRAME_CYC));
    check_eq("a5_frames", 32'(frames), 32'd1);

    // Load while busy is dropped with a one-cycle pulse.
    clear_counts();
    load_pulse(8'h3C);
    run_cycles(9);
    load_pulse(8'hFF);
    run_cycles(FRAME_CYC);
    check_eq("3c_drops", 32'(drops), 32'd1);
    check_eq("3c_frames", 32'(frames), 32'd1);

    // Strobe held low: exactly one frame.
    clear_counts();
    load_n = 1'b0;
    data   = 8'h01;
    run_cycles(100);
    load_n = 1'b1;
    run_cycles(10);
    check_eq("held_frames", 32'(frames), 32'd1);

    // Reset mid-frame, then a full frame.
    load_pulse(DW'($urandom));
    run_cycles(14);
    rst_n = 1'b0;
    cycle();
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    run_cycles(3);
    clear_counts();
    load_pulse(DW'($urandom));
    run_cycles(FRAME_CYC + 4);
    check_eq("post_rst_busy_cycles", 32'(busy_cycles), 32'(FRAME_CYC));

    // Back-to-back frames, second load in first non-busy cycle.
    clear_counts();
    load_pulse(8'h00);
    begin
      int n = 0;
      while (busy === 1'b1 && n < 200) begin
        cycle();
        n++;
      end
      check_eq("b2b_busy_fell", 32'(busy === 1'b0), 32'd1);
    end
    load_pulse(8'hFF);
    check_eq("b2b_second_start_tx", 32'(tx), 32'd0);
    check_eq("b2b_second_busy", 32'(busy), 32'd1);
    run_cycles(FRAME_CYC + 4);
    check_eq("b2b_busy_cycles", 32'(busy_cycles), 32'(2 * FRAME_CYC));
    check_eq("b2b_drops", 32'(drops), 32'd0);

    // Strobe low while reset releases counts as a load.
    clear_counts();
    rst_n  = 1'b0;
    load_n = 1'b0;
    data   = 8'h5A;
    cycle();
    rst_n = 1'b1;
    run_cycles(FRAME_CYC + 4);
    load_n = 1'b1;
    check_eq("rst_load_frames", 32'(frames), 32'd1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      load_n = ($urandom_range(0, 7) != 0);
      data   = DW'($urandom);
      rst_n  = ($urandom_range(0, 199) != 0);
      cycle();
    end
    rst_n  = 1'b1;
    load_n = 1'b1;
    run_cycles(FRAME_CYC + 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sc_randuart.md
SC_RANDUART -- requirements
Module: sc_randuart

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, meaning width of transmitted word.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 434, meaning clock cycles per serial bit (115200 baud at 50 MHz); legal values are 2 or more.
REQ-003 SHALL have port SC_RANDUART_CLOCK_50  in  1  sole clock; all state updates occur on its rising edge.
REQ-004 SHALL have port SC_RANDUART_RESET_InLow  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port SC_RANDUART_load_InLow  in  1  active-low load strobe, the same strobe that loads the random-value register.
REQ-006 SHALL have port SC_RANDUART_data_InBUS  in  DATAWIDTH  random value to transmit.
REQ-007 SHALL have port SC_RANDUART_tx_Out  out  1  serial line, idle high.
REQ-008 SHALL have port SC_RANDUART_busy_Out  out  1  high while a frame is in progress.
REQ-009 SHALL have port SC_RANDUART_drop_Out  out  1  one-cycle pulse when a load arrives while busy.

Function
REQ-010 SHALL detect a load as a falling edge: load_InLow sampled low at this edge and high at the previous edge.
REQ-011 SHALL treat a load_InLow held low as one load only, with no repeated frames.
REQ-012 SHALL, on a load while idle, capture data_InBUS into an internal shift register, and in the next cycle drive tx_Out=0 (start bit) and busy_Out=1.
REQ-013 SHALL keep each bit on tx_Out for exactly CLKS_PER_BIT cycles.
REQ-014 SHALL send frame order start(0), DATAWIDTH data bits LSB first, optional parity, stop(1).
REQ-015 SHALL use states IDLE, START, DATA, PARITY, STOP with transitions IDLE->START on load; START->DATA after one bit time; DATA->DATA until bit index DATAWIDTH-1; DATA->PARITY (or STOP) after last bit; PARITY->STOP; STOP->IDLE after one bit time.
REQ-016 SHALL deassert busy_Out in the cycle after the stop bit time ends, so a frame occupies (DATAWIDTH+2)*CLKS_PER_BIT cycles, or +CLKS_PER_BIT with parity.
REQ-017 SHALL accept a load in the first cycle in which busy_Out is low, allowing back-to-back frames without idle gap beyond one cycle.
REQ-018 SHALL ignore a load while busy_Out=1: the frame in progress is unaffected and drop_Out pulses high for exactly one cycle.
REQ-019 SHALL NOT let changes to data_InBUS after capture affect the frame in progress.
REQ-020 SHALL implement the baud counter as 0..CLKS_PER_BIT-1 wrapping to 0 on each bit boundary, and the bit index as 0..DATAWIDTH-1.

Reset
REQ-021 SHALL, when RESET_InLow=0 at an edge, set state=IDLE, tx_Out=1, busy_Out=0, drop_Out=0, counters=0, shift register=0, load-edge history=1.
REQ-022 SHALL, on reset mid-frame, abandon the frame with tx_Out high on the next edge and no resume.
REQ-023 SHALL, when load_InLow is low when reset releases, count it as a load, because the history resets to 1.

Configuration
REQ-024 SHALL, with SC_RANDUART_PARITY_EN defined, insert an even-parity bit (XOR of the captured data) between the last data bit and stop, and include the PARITY state.
REQ-025 SHALL, with SC_RANDUART_PARITY_EN undefined, contain no PARITY state or parity logic; DATA goes directly to STOP.

Structure
REQ-026 SHALL place the state enumeration, the CLKS_PER_BIT default constant and the frame-length constants in shared package sc_randuart_pkg.
REQ-027 SHALL implement the baud counter and bit-tick generation as sub-module sc_randuart_baudgen.

Verification (CLKS_PER_BIT=4, DATAWIDTH=8)
REQ-028 SHALL cover: reset, then idle 20 cycles -> tx_Out=1, busy_Out=0, drop_Out=0 throughout.
REQ-029 SHALL cover: load 8'hA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1 with each level 4 cycles; busy_Out high for 40 cycles; parity build adds 0 before stop and 44 cycles.
REQ-030 SHALL cover: load 8'h3C, then a second load at cycle 10 of the frame with data 8'hFF -> drop_Out pulses 1 cycle; the frame still carries 8'h3C.
REQ-031 SHALL cover: load_InLow held low for 100 cycles with 8'h01 -> exactly one frame, then tx_Out stays idle.
REQ-032 SHALL cover: reset asserted at cycle 15 of a frame -> next edge tx_Out=1 and busy_Out=0; a new load after release sends a full frame.
REQ-033 SHALL cover: a load in the first cycle busy_Out falls, with 8'h00 then 8'hFF -> two complete frames, with the second start bit in the following cycle.
